// File: rtl/vga_pkg.sv
// Shared VGA types and text-grid geometry for the menu draw chain.
package vga_pkg;

  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;
  localparam int TEXT_COLS = 16;
  localparam int TEXT_ROWS = 16;

  // Pixel extent of the full text box
  localparam int BOX_W = CHAR_W * TEXT_COLS;
  localparam int BOX_H = CHAR_H * TEXT_ROWS;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_if_t;

  // Glyph rows are MSB-first, so pixel column 0 maps to bit 7
  function automatic logic [2:0] glyph_bit(input logic [2:0] col_px);
    return 3'd7 - col_px;
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth shift register for the VGA timing/colour bundle.
module vga_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  vga_if_t vga_in,
  output vga_if_t vga_out
);

  vga_if_t stage_q [DEPTH];

  // Shift the bundle one stage per clock; all stages clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= vga_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign vga_out = stage_q[DEPTH-1];

endmodule

// File: rtl/menu_text_draw.sv
// Draws a 16x16-character menu text box over the VGA stream with a
// blinking highlight on the selected row. Three-stage pixel pipeline.
module menu_text_draw
  import vga_pkg::*;
#(
  parameter logic [10:0] XPOS         = 11'd256,
  parameter logic [10:0] YPOS         = 11'd128,
  parameter logic [11:0] TEXT_COLOR   = 12'hFFF,
  parameter logic [11:0] HL_COLOR     = 12'hF80,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [3:0]  sel_row,
  input  logic        sel_en,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Box-relative coordinates of the incoming pixel
  logic [10:0] dx, dy;
  logic        in_box;

  assign dx     = hcount_in - XPOS;
  assign dy     = vcount_in - YPOS;
  assign in_box = (hcount_in >= XPOS) && (dx < 11'(BOX_W)) &&
                  (vcount_in >= YPOS) && (dy < 11'(BOX_H));

  // Text ROM address goes out immediately so char_code lines up with char_line
  assign char_xy = in_box ? {dy[7:4], dx[6:3]} : 8'h00;

  // Stage 1: glyph line to the font ROM plus position bits for later stages
  logic [3:0] char_line_q;
  logic [2:0] dx_lo_q;
  logic       in_box1_q;
  logic [3:0] row1_q;

  // Register the addressing stage alongside the text ROM lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_line_q <= '0;
      dx_lo_q     <= '0;
      in_box1_q   <= 1'b0;
      row1_q      <= '0;
    end else begin
      char_line_q <= dy[3:0];
      dx_lo_q     <= dx[2:0];
      in_box1_q   <= in_box;
      row1_q      <= dy[7:4];
    end
  end

  assign char_line = char_line_q;

  // Stage 2: bit select held while the font ROM produces char_pixels
  logic [2:0] bit_q;
  logic       in_box2_q;
  logic [3:0] row2_q;

  // Carry position forward to meet the font ROM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q     <= '0;
      in_box2_q <= 1'b0;
      row2_q    <= '0;
    end else begin
      bit_q     <= glyph_bit(dx_lo_q);
      in_box2_q <= in_box1_q;
      row2_q    <= row1_q;
    end
  end

  // Blink phase: frame counter advanced on each vsync rising edge
  logic        vsync_q;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic        vsync_rise;

  assign vsync_rise = vsync_in && !vsync_q;

  // Count frames and flip the phase each time BLINK_FRAMES have elapsed
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (vsync_rise) begin
      if (blink_cnt_q == 16'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  // Hold the vsync edge detector and blink state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vsync_q       <= vsync_in;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Stage 3: decide glyph hit and its colour from the font ROM data
  logic        pix_on_d;
  logic [11:0] glyph_color_d;
  logic        pix_on_q;
  logic [11:0] glyph_color_q;

  assign pix_on_d      = in_box2_q && char_pixels[bit_q];
  assign glyph_color_d = (sel_en && (row2_q == sel_row) && blink_phase_q) ?
                         HL_COLOR : TEXT_COLOR;

  // Register the overlay decision in step with the delayed timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_on_q      <= 1'b0;
      glyph_color_q <= '0;
    end else begin
      pix_on_q      <= pix_on_d;
      glyph_color_q <= glyph_color_d;
    end
  end

  // Timing and background colour ride a matching three-stage delay
  vga_if_t vga_in_s, vga_dly;

  assign vga_in_s = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                      vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in,
                      rgb: rgb_in};

  vga_delay #(.DEPTH(3)) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .vga_in  (vga_in_s),
    .vga_out (vga_dly)
  );

  assign hcount_out = vga_dly.hcount;
  assign hsync_out  = vga_dly.hsync;
  assign hblnk_out  = vga_dly.hblnk;
  assign vcount_out = vga_dly.vcount;
  assign vsync_out  = vga_dly.vsync;
  assign vblnk_out  = vga_dly.vblnk;

  // Blanking forces black; otherwise glyph pixels win over the background
  assign rgb_out = (vga_dly.hblnk || vga_dly.vblnk) ? 12'h000 :
                   pix_on_q ? glyph_color_q : vga_dly.rgb;

endmodule

// File: doc/menu_text_draw.md
Name: menu_text_draw

Overview:
- Renders one 16x16-character menu text box onto the VGA stream.
- Generates the character address `char_xy` for the menu text ROM (`menu_text*`, registered, 1-cycle latency), and `char_line` for the font ROM (registered, 1-cycle latency).
- Overlays the returned glyph row on `rgb_in`, with a blinking highlight on the selected menu row.
- Sits in the menu draw chain, between the background/timing stage and the next overlay stage.

Parameters:
- XPOS, 11'd256, left pixel column of the text box.
- YPOS, 11'd128, top pixel row of the text box.
- TEXT_COLOR, 12'hFFF, glyph colour for unselected rows.
- HL_COLOR, 12'hF80, alternate glyph colour for the selected row.
- BLINK_FRAMES, 30, frames per blink phase; minimum 1.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hcount_in  in  11  horizontal pixel counter
- hsync_in  in  1  horizontal sync
- hblnk_in  in  1  horizontal blank
- vcount_in  in  11  vertical line counter
- vsync_in  in  1  vertical sync
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  incoming pixel colour
- sel_row  in  4  selected menu row, 0..15
- sel_en  in  1  highlight enable
- char_xy  out  8  {row[3:0], col[3:0]} to the text ROM
- char_line  out  4  glyph line to the font ROM
- char_pixels  in  8  glyph row from the font ROM, MSB = leftmost pixel
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  delayed timing
- rgb_out  out  12  composited pixel

Behaviour:
- Reset is asynchronous, active-low, and clock-only otherwise.
- While rst_n=0:
  - every registered output is 0: all timing outputs, rgb_out and char_line;
  - blink counter = 0, blink phase = 0, vsync edge register = 0.
- Box geometry:
  - dx = hcount_in − XPOS, dy = vcount_in − YPOS, both 11-bit.
  - in_box = (hcount_in ≥ XPOS) && (dx < 128) && (vcount_in ≥ YPOS) && (dy < 256).
- char_xy is combinational from the cycle-T inputs: {dy[7:4], dx[6:3]}. Outside the box it is 8'h00.
- Stage 1 (T+1) registers:
  - char_line = dy[3:0], so it is aligned with the text ROM's char_code;
  - dx[2:0], in_box, and the row index dy[7:4].
- Stage 2 (T+2): the font ROM returns char_pixels. The block registers bit index 7 − dx[2:0], plus in_box and row.
- Stage 3 (T+3), output register:
  - if hblnk or vblnk is delayed-active: rgb_out = 12'h000;
  - else if in_box && char_pixels[bit]: rgb_out = glyph colour;
  - else rgb_out = rgb_in delayed by 3 cycles.
- Glyph colour is HL_COLOR when sel_en && row == sel_row && blink phase = 1; otherwise TEXT_COLOR.
- All timing signals and rgb_in pass through exactly 3 register stages. Total latency is 3 cycles for every output except char_xy (0) and char_line (1).
- Blink counter:
  - increments on each vsync_in rising edge (registered edge detect);
  - on reaching BLINK_FRAMES−1 it wraps to 0 and toggles the phase.
- sel_row / sel_en changes take effect on the next pixel; there is no frame-boundary latching.
- Boundary values:
  - hcount_in = XPOS+127 is inside the box (col 15, bit 0); XPOS+128 is outside.
  - vcount_in = YPOS+255 is inside; YPOS+256 is outside.
  - XPOS+128 > 2047 is illegal; no wrap handling.
- rst_n deasserted mid-line: pipeline outputs are zero for 3 cycles, then track the inputs. The blink counter restarts from 0.

Decomposition:
- vga_pkg adds:
  - CHAR_W = 8, CHAR_H = 16, TEXT_COLS = 16, TEXT_ROWS = 16;
  - a `vga_if_t` struct {hcount, hsync, hblnk, vcount, vsync, vblnk, rgb}.
- One sub-module, `vga_delay #(DEPTH)`, is a shift register of `vga_if_t` with async active-low reset. It is instantiated with DEPTH=3 for the timing path.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0; release → rgb_out equals rgb_in delayed exactly 3 cycles outside the box.
- Addressing: hcount_in=XPOS+19, vcount_in=YPOS+37 → char_xy=8'h22 in the same cycle; char_line=4'h5 one cycle later.
- Glyph draw: font model returns 8'b1000_0000; pixels at dx=16 and dx=17 → rgb_out at T+3 is TEXT_COLOR, then the delayed rgb_in.
- Box edges: dx=127 with char_pixels bit0=1 → TEXT_COLOR; dx=128 → rgb_in passthrough, char_xy=8'h00.
- Blanking: hblnk_in=1 inside the box with glyph bit set → rgb_out=12'h000 at T+3.
- Blink: sel_en=1, sel_row=2, BLINK_FRAMES=2, glyph pixel on row 2 → colour is TEXT_COLOR for frames 0–1, HL_COLOR for frames 2–3, TEXT_COLOR again from frame 4; row 3 stays TEXT_COLOR throughout.
